// File: rtl/sar_pkg.sv
// Shared types and defaults for the SAR conversion controller.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    WAIT_CMP,
    DONE
  } sar_state_t;

  localparam int unsigned N_BITS_DEF      = 8;
  localparam int unsigned SETTLE_CYC_DEF  = 2;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;

  // Shared timer must cover both the settle window (<=15) and the watchdog limit.
  function automatic int unsigned cnt_w(input int unsigned timeout_cyc);
    return $clog2((timeout_cyc > 16) ? timeout_cyc : 16);
  endfunction

  localparam int unsigned CNT_W = cnt_w(TIMEOUT_CYC_DEF);

endpackage

// File: rtl/sar_timer.sv
// Loadable up-counter with synchronous clear and a terminal-count compare.
module sar_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_ld,
  input  logic [W-1:0] i_ld_val,
  input  logic         i_en,
  input  logic [W-1:0] i_tc_val,
  output logic         o_tc_c
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_ld) begin
      r_cnt <= i_ld_val;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_tc_c = (r_cnt == i_tc_val);

endmodule

// File: rtl/sar_logic.sv
// Successive-approximation controller: drives CDAC trial code and comparator triggers.
// Optional comparator watchdog enabled with `define SAR_TIMEOUT_EN.
module sar_logic
  import sar_pkg::*;
#(
  parameter int unsigned N_BITS      = N_BITS_DEF,
  parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cmp_rdy,
  input  logic              cmp_dec,
  output logic              cmp_trig,
  output logic [N_BITS-1:0] dac_p,
  output logic              eoc,
  output logic [N_BITS-1:0] dout,
  output logic              dout_vld,
  output logic              timeout_err
);

  localparam int unsigned TMR_W = cnt_w(TIMEOUT_CYC);
  localparam int unsigned IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  sar_state_t        r_state, w_state_nxt;
  logic [N_BITS-1:0] r_dac, w_dac_nxt;
  logic [N_BITS-1:0] r_dout, w_dout_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt, w_idx_m1;
  logic              r_trig, w_trig_nxt;
  logic              r_eoc, w_eoc_nxt;
  logic              r_vld, w_vld_nxt;
  logic              r_terr, w_terr_nxt;

  logic              w_tmr_clr, w_tmr_en, w_tmr_tc, w_timeout, w_dec;
  logic [TMR_W-1:0]  w_tmr_tc_val;

`ifdef SAR_TIMEOUT_EN
  assign w_tmr_tc_val = (r_state == WAIT_CMP) ? TMR_W'(TIMEOUT_CYC - 1) : TMR_W'(SETTLE_CYC - 1);
  assign w_timeout    = (r_state == WAIT_CMP) && w_tmr_tc && !cmp_rdy;
`else
  assign w_tmr_tc_val = TMR_W'(SETTLE_CYC - 1);
  assign w_timeout    = 1'b0;
`endif

  // A watchdog expiry is resolved as a "Vin below trial" decision.
  assign w_dec    = cmp_rdy & cmp_dec;
  assign w_idx_m1 = r_idx - IDX_W'(1);

  sar_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_tmr_clr),
    .i_ld     (1'b0),
    .i_ld_val ('0),
    .i_en     (w_tmr_en),
    .i_tc_val (w_tmr_tc_val),
    .o_tc_c   (w_tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_dac   <= '0;
      r_dout  <= '0;
      r_idx   <= IDX_W'(N_BITS - 1);
      r_trig  <= 1'b0;
      r_eoc   <= 1'b0;
      r_vld   <= 1'b0;
      r_terr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dac   <= w_dac_nxt;
      r_dout  <= w_dout_nxt;
      r_idx   <= w_idx_nxt;
      r_trig  <= w_trig_nxt;
      r_eoc   <= w_eoc_nxt;
      r_vld   <= w_vld_nxt;
      r_terr  <= w_terr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dac_nxt   = r_dac;
    w_dout_nxt  = r_dout;
    w_idx_nxt   = r_idx;
    w_trig_nxt  = 1'b0;
    w_eoc_nxt   = r_eoc;
    w_vld_nxt   = 1'b0;
    w_terr_nxt  = r_terr;
    w_tmr_clr   = 1'b0;
    w_tmr_en    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start && !r_eoc) begin
          w_state_nxt            = SETTLE;
          w_dac_nxt              = '0;
          w_dac_nxt[N_BITS-1]    = 1'b1;
          w_idx_nxt              = IDX_W'(N_BITS - 1);
          w_tmr_clr              = 1'b1;
`ifdef SAR_TIMEOUT_EN
          w_terr_nxt             = 1'b0;
`endif
        end
      end
      SETTLE: begin
        if (!start) begin
          w_state_nxt = IDLE;
          w_dac_nxt   = '0;
          w_tmr_clr   = 1'b1;
        end else if (w_tmr_tc) begin
          w_trig_nxt  = 1'b1;
          w_state_nxt = WAIT_CMP;
          w_tmr_clr   = 1'b1;
        end else begin
          w_tmr_en    = 1'b1;
        end
      end
      WAIT_CMP: begin
        if (!start) begin
          w_state_nxt = IDLE;
          w_dac_nxt   = '0;
          w_tmr_clr   = 1'b1;
        end else if (cmp_rdy || w_timeout) begin
          if (!w_dec) w_dac_nxt[r_idx] = 1'b0;
          if (w_timeout) w_terr_nxt = 1'b1;
          w_tmr_clr = 1'b1;
          if (r_idx != '0) begin
            w_dac_nxt[w_idx_m1] = 1'b1;
            w_idx_nxt           = w_idx_m1;
            w_state_nxt         = SETTLE;
          end else begin
            w_dout_nxt  = w_dac_nxt;
            w_vld_nxt   = 1'b1;
            w_eoc_nxt   = 1'b1;
            w_state_nxt = DONE;
          end
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      DONE: begin
        // eoc stays up until the divider drops start, preventing a re-trigger.
        if (!start) begin
          w_eoc_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign cmp_trig    = r_trig;
  assign dac_p       = r_dac;
  assign eoc         = r_eoc;
  assign dout        = r_dout;
  assign dout_vld    = r_vld;
  assign timeout_err = r_terr;

endmodule

// File: doc/sar_logic.md
Name: sar_logic

Overview:
Successive-approximation controller directly downstream of the sample/start clock divider in the time-domain SAR ADC.
- Converts on each `start` level from the divider.
- Drives the capacitive-DAC trial code and fires the time-domain (VCDL) comparator once per bit.
- Returns `eoc` to the divider, which releases `start`.
- Presents the final code with a one-cycle valid strobe.

Parameters:
- N_BITS, 8: resolution; DAC and output width.
- SETTLE_CYC, 2: DAC settling cycles before each comparator trigger; legal range 1..15.
- TIMEOUT_CYC, 64: comparator watchdog limit in cycles; used only with SAR_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  conversion request level from the divider.
- cmp_rdy  in  1  one-cycle comparator decision-ready pulse.
- cmp_dec  in  1  comparator decision, valid with cmp_rdy; 1 = Vin >= trial.
- cmp_trig  out  1  one-cycle comparator fire pulse.
- dac_p  out  N_BITS  trial code to the CDAC switches.
- eoc  out  1  end of conversion, level.
- dout  out  N_BITS  converted code.
- dout_vld  out  1  one-cycle strobe when dout updates.
- timeout_err  out  1  sticky comparator-timeout flag.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE.
  - dac_p=0, dout=0, cmp_trig=0, eoc=0, dout_vld=0, timeout_err=0.
  - Bit index=N_BITS-1, settle counter=0.
- States: IDLE, SETTLE, WAIT_CMP, DONE.
- IDLE:
  - Exit when start=1 and eoc=0.
  - On exit: dac_p <= 1<<(N_BITS-1), idx <= N_BITS-1, cnt <= 0, go to SETTLE.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYC-1: cmp_trig=1 for exactly the next cycle, go to WAIT_CMP.
  - cmp_trig is 0 in every other case.
- WAIT_CMP:
  - Wait for cmp_rdy. On cmp_rdy, if cmp_dec=0, clear dac_p[idx].
  - If idx>0: set dac_p[idx-1], decrement idx, cnt <= 0, go to SETTLE.
  - If idx==0: dout <= final dac_p including this decision, dout_vld=1 for one cycle, eoc <= 1, go to DONE.
- DONE:
  - eoc held high while start=1.
  - On start=0: eoc <= 0, go to IDLE.
  - dac_p and dout retained until the next conversion.
- Abort: start=0 in SETTLE or WAIT_CMP gives IDLE next cycle with dac_p=0, no eoc, no dout_vld, and dout unchanged.
- cmp_rdy outside WAIT_CMP is ignored.
- cmp_rdy in the same cycle as abort: abort wins.
- start still high after eoc drops: no new conversion until start has been seen low. The IDLE guard eoc=0 plus the DONE exit enforces this.
- Latency from start rise to dout_vld: 1 + N_BITS*(SETTLE_CYC + 1 + Tcmp) cycles, where Tcmp is the cycles from cmp_trig to cmp_rdy.
- Reset mid-conversion: immediate return to reset values; no eoc.

Optional Feature:
- Macro SAR_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in WAIT_CMP.
  - If it reaches TIMEOUT_CYC without cmp_rdy, treat the decision as cmp_dec=0 and proceed normally.
  - timeout_err is set and held until the next IDLE->SETTLE transition.
- Undefined:
  - WAIT_CMP waits indefinitely.
  - timeout_err is tied to 0.

Decomposition:
- Package sar_pkg holds:
  - state enum sar_state_t {IDLE, SETTLE, WAIT_CMP, DONE};
  - default N_BITS and SETTLE_CYC constants;
  - counter width constant CNT_W=$clog2(max(TIMEOUT_CYC,16)).
- One sub-module, sar_timer: loadable up-counter with clear and terminal-count flag. It is shared between settle timing and the timeout watchdog.

Test Plan:
- N_BITS=4, SETTLE_CYC=2, comparator model with Vin code 10, Tcmp=1:
  - dac_p sequence 1000, 1100, 1010, 1011;
  - dout=1010 with dout_vld for one cycle;
  - eoc high until start drops.
- Vin code 15 (all decisions 1): dout=1111. Vin code 0: dout=0000, final dac_p=0000.
- Drop start during the third WAIT_CMP -> next cycle IDLE, dac_p=0, no dout_vld, eoc stays 0, dout keeps its previous value.
- Spurious cmp_rdy pulses in IDLE and SETTLE -> no state or dac_p change. Assert rst mid-conversion -> all outputs reach reset values at the next edge.
- Hold start high across eoc -> eoc stays 1, no restart; lower start -> eoc 0; raise start -> new conversion begins.
- SAR_TIMEOUT_EN, TIMEOUT_CYC=8, comparator silent on the MSB:
  - after 8 cycles in WAIT_CMP, bit 3 is cleared and timeout_err=1;
  - timeout_err clears on the next conversion start.
